// File: rtl/cp0_ctrl.sv
// cp0_ctrl: coprocessor-0 exception/interrupt controller holding SR, Cause, EPC and PRId.
// Optional macro CP0_BD_EN enables branch-delay-slot EPC rewind and Cause.BD.
module cp0_ctrl #(
  parameter logic [31:0] PRID_VAL     = 32'h1705_0007,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  HWInt,
  input  logic        ExcReq,
  input  logic [4:0]  ExcCode_In,
  input  logic [31:0] PC_M,
  input  logic        BD_In,
  input  logic        CP0We,
  input  logic [4:0]  CP0Addr,
  input  logic [31:0] CP0DataIn,
  input  logic        EXLClr,
  output logic [31:0] CP0DataOut,
  output logic        IntReq,
  output logic [31:0] EPC
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR.EXL is the state bit: NORMAL accepts traps, HANDLER blocks nesting.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } exl_state_t;

  exl_state_t  state_r;
  exl_state_t  state_nxt_s;
  logic [5:0]  im_r;
  logic [5:0]  im_nxt_s;
  logic        ie_r;
  logic        ie_nxt_s;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  logic [4:0]  exc_code_nxt_s;
  logic        bd_r;
  logic        bd_nxt_s;
  logic [31:0] epc_r;
  logic [31:0] epc_nxt_s;

  logic        exl_s;
  logic        int_s;
  logic        exc_s;
  logic        int_req_s;
  logic        sr_we_s;
  logic        epc_we_s;
  logic        exl_wr_s;
  logic [31:0] trap_epc_s;
  logic        trap_bd_s;
  logic [31:0] rd_data_s;

  assign exl_s     = (state_r == HANDLER);
  assign int_s     = (|(HWInt & im_r)) & ie_r & ~exl_s;
  assign exc_s     = ExcReq & ~exl_s;
  assign int_req_s = int_s | exc_s;
  assign sr_we_s   = CP0We & (CP0Addr == ADDR_SR);
  assign epc_we_s  = CP0We & (CP0Addr == ADDR_EPC);
  // An SR write lands first, then a coincident eret clears EXL on top of it.
  assign exl_wr_s  = sr_we_s ? CP0DataIn[1] : exl_s;

`ifdef CP0_BD_EN
  assign trap_epc_s = BD_In ? ({PC_M[31:2], 2'b00} - 32'd4) : {PC_M[31:2], 2'b00};
  assign trap_bd_s  = BD_In;
  logic unused_ok;
  assign unused_ok = &{1'b0, PC_M[1:0], HANDLER_ADDR[0]};
`else
  assign trap_epc_s = {PC_M[31:2], 2'b00};
  assign trap_bd_s  = 1'b0;
  logic unused_ok;
  assign unused_ok = &{1'b0, PC_M[1:0], BD_In, HANDLER_ADDR[0]};
`endif

  // Next-state and register update selection; a trap overrides any mtc0.
  always_comb begin
    state_nxt_s    = state_r;
    im_nxt_s       = im_r;
    ie_nxt_s       = ie_r;
    exc_code_nxt_s = exc_code_r;
    bd_nxt_s       = bd_r;
    epc_nxt_s      = epc_r;
    if (int_req_s) begin
      state_nxt_s    = HANDLER;
      epc_nxt_s      = trap_epc_s;
      exc_code_nxt_s = int_s ? 5'd0 : ExcCode_In;
      bd_nxt_s       = trap_bd_s;
    end else begin
      if (sr_we_s) begin
        im_nxt_s = CP0DataIn[15:10];
        ie_nxt_s = CP0DataIn[0];
      end else begin
        im_nxt_s = im_r;
        ie_nxt_s = ie_r;
      end
      if (epc_we_s) begin
        epc_nxt_s = {CP0DataIn[31:2], 2'b00};
      end else begin
        epc_nxt_s = epc_r;
      end
      if (exl_wr_s & ~EXLClr) begin
        state_nxt_s = HANDLER;
      end else begin
        state_nxt_s = NORMAL;
      end
    end
  end

  // CP0 state registers; Cause.IP tracks the interrupt lines every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= NORMAL;
      im_r       <= 6'd0;
      ie_r       <= 1'b0;
      ip_r       <= 6'd0;
      exc_code_r <= 5'd0;
      bd_r       <= 1'b0;
      epc_r      <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      im_r       <= im_nxt_s;
      ie_r       <= ie_nxt_s;
      ip_r       <= HWInt;
      exc_code_r <= exc_code_nxt_s;
      bd_r       <= bd_nxt_s;
      epc_r      <= epc_nxt_s;
    end
  end

  // mfc0 read mux; no bypass of same-cycle writes.
  always_comb begin
    rd_data_s = 32'd0;
    case (CP0Addr)
      ADDR_SR:    rd_data_s = {16'd0, im_r, 8'd0, exl_s, ie_r};
      ADDR_CAUSE: rd_data_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
      ADDR_EPC:   rd_data_s = epc_r;
      ADDR_PRID:  rd_data_s = PRID_VAL;
      default:    rd_data_s = 32'd0;
    endcase
  end

  assign CP0DataOut = rd_data_s;
  assign IntReq     = int_req_s;
  assign EPC        = epc_r;

endmodule

// File: tb/tb_cp0_ctrl.sv
// tb_cp0_ctrl: directed vector table, reset-in-handler sequence and a randomized
// run checked against a register-image reference model of CP0.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic [5:0]  HWInt;
  logic        ExcReq;
  logic [4:0]  ExcCode_In;
  logic [31:0] PC_M;
  logic        BD_In;
  logic        CP0We;
  logic [4:0]  CP0Addr;
  logic [31:0] CP0DataIn;
  logic        EXLClr;
  logic [31:0] CP0DataOut;
  logic        IntReq;
  logic [31:0] EPC;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] PRID = 32'h1705_0007;
`ifdef CP0_BD_EN
  localparam logic [31:0] BD_EPC   = 32'h0000_303C;
  localparam logic [31:0] BD_CAUSE = 32'h8000_0400;
`else
  localparam logic [31:0] BD_EPC   = 32'h0000_3040;
  localparam logic [31:0] BD_CAUSE = 32'h0000_0400;
`endif

  cp0_ctrl dut (
    .clk(clk), .reset(reset), .HWInt(HWInt), .ExcReq(ExcReq), .ExcCode_In(ExcCode_In),
    .PC_M(PC_M), .BD_In(BD_In), .CP0We(CP0We), .CP0Addr(CP0Addr), .CP0DataIn(CP0DataIn),
    .EXLClr(EXLClr), .CP0DataOut(CP0DataOut), .IntReq(IntReq), .EPC(EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        clr;
    logic        bd;
    logic        e_int;
    logic [31:0] e_epc;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl[34];

  // Reference model: architectural register images with their writable masks.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic m_int();
    return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_exc();
    return ExcReq && !m_sr[1];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic [31:0] sr, cause, epc;
    logic ti, te;
    if (reset) begin
      m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
      return;
    end
    ti = m_int(); te = m_exc();
    sr = m_sr; cause = m_cause; epc = m_epc;
    cause[15:10] = HWInt;
    if (ti || te) begin
      sr[1] = 1'b1;
      epc = PC_M & 32'hFFFF_FFFC;
      cause[6:2] = ti ? 5'd0 : ExcCode_In;
`ifdef CP0_BD_EN
      if (BD_In) epc = epc - 32'd4;
      cause[31] = BD_In;
`endif
    end else begin
      if (CP0We && CP0Addr == 5'd12) sr = CP0DataIn & 32'h0000_FC03;
      if (CP0We && CP0Addr == 5'd14) epc = CP0DataIn & 32'hFFFF_FFFC;
      if (EXLClr) sr[1] = 1'b0;
    end
    m_sr = sr; m_cause = cause; m_epc = epc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    CP0We = v.we; CP0Addr = v.addr; CP0DataIn = v.din; HWInt = v.hw; ExcReq = v.exc;
    ExcCode_In = v.code; PC_M = v.pc; EXLClr = v.clr; BD_In = v.bd;
  endtask

  task automatic run_cycle(input string tag, input logic e_int, input logic [31:0] e_epc,
                           input logic [31:0] e_rd);
    @(negedge clk);
    check({tag, " IntReq"}, {31'd0, IntReq}, {31'd0, e_int});
    check({tag, " EPC"}, EPC, e_epc);
    check({tag, " CP0DataOut"}, CP0DataOut, e_rd);
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] addr, input logic [31:0] din,
                              input logic [5:0] hw, input logic exc, input logic [4:0] code,
                              input logic [31:0] pc, input logic clr, input logic bd,
                              input logic e_int, input logic [31:0] e_epc,
                              input logic [31:0] e_rd);
    vec_t v;
    v.we = we; v.addr = addr; v.din = din; v.hw = hw; v.exc = exc; v.code = code;
    v.pc = pc; v.clr = clr; v.bd = bd; v.e_int = e_int; v.e_epc = e_epc; v.e_rd = e_rd;
    return v;
  endfunction

  initial begin
    vec_t v;
    string tag;
    // we addr din hw exc code pc clr bd | int epc rd
    tbl[0]  = mk(1'b0, 5'd12, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0);
    tbl[1]  = mk(1'b0, 5'd13, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0);
    tbl[2]  = mk(1'b0, 5'd14, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0);
    tbl[3]  = mk(1'b0, 5'd15, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    PRID);
    tbl[4]  = mk(1'b0, 5'd5,  32'h0, 6'h3F, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    32'h0);
    tbl[5]  = mk(1'b1, 5'd12, 32'h0000_FC01, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tbl[6]  = mk(1'b0, 5'd13, 32'h0, 6'h01, 1'b0, 5'd0,  32'h3010, 1'b0, 1'b0, 1'b1, 32'h0,    32'h0);
    tbl[7]  = mk(1'b0, 5'd12, 32'h0, 6'h3F, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3010, 32'hFC03);
    tbl[8]  = mk(1'b0, 5'd13, 32'h0, 6'h3F, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3010, 32'hFC00);
    tbl[9]  = mk(1'b0, 5'd12, 32'h0, 6'h3F, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h3010, 32'hFC03);
    tbl[10] = mk(1'b0, 5'd12, 32'h0, 6'h3F, 1'b0, 5'd0,  32'h3020, 1'b0, 1'b0, 1'b1, 32'h3010, 32'hFC01);
    tbl[11] = mk(1'b1, 5'd12, 32'h0000_0401, 6'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3020, 32'hFC03);
    tbl[12] = mk(1'b0, 5'd12, 32'h0, 6'h00, 1'b1, 5'd12, 32'h3024, 1'b0, 1'b0, 1'b1, 32'h3020, 32'h0401);
    tbl[13] = mk(1'b0, 5'd13, 32'h0, 6'h00, 1'b1, 5'd10, 32'h3070, 1'b0, 1'b0, 1'b0, 32'h3024, 32'h0030);
    tbl[14] = mk(1'b1, 5'd12, 32'h0000_0401, 6'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3024, 32'h0403);
    tbl[15] = mk(1'b0, 5'd14, 32'h0, 6'h01, 1'b1, 5'd12, 32'h3028, 1'b0, 1'b0, 1'b1, 32'h3024, 32'h3024);
    tbl[16] = mk(1'b0, 5'd13, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3028, 32'h0400);
    tbl[17] = mk(1'b1, 5'd12, 32'h0000_0401, 6'h00, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h3028, 32'h0403);
    tbl[18] = mk(1'b1, 5'd14, 32'hDEAD_BEEF, 6'h01, 1'b0, 5'd0, 32'h3030, 1'b0, 1'b0, 1'b1, 32'h3028, 32'h3028);
    tbl[19] = mk(1'b0, 5'd14, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3030, 32'h3030);
    tbl[20] = mk(1'b1, 5'd12, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 32'h3030, 32'h0403);
    tbl[21] = mk(1'b1, 5'd14, 32'h0000_3007, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3030, 32'h3030);
    tbl[22] = mk(1'b0, 5'd14, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3004, 32'h3004);
    tbl[23] = mk(1'b1, 5'd13, 32'hFFFF_FFFF, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3004, 32'h0);
    tbl[24] = mk(1'b1, 5'd15, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3004, PRID);
    tbl[25] = mk(1'b0, 5'd13, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3004, 32'h0);
    tbl[26] = mk(1'b1, 5'd12, 32'h0000_FC01, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h3004, 32'h0);
    tbl[27] = mk(1'b0, 5'd14, 32'h0, 6'h01, 1'b0, 5'd0,  32'h3040, 1'b0, 1'b1, 1'b1, 32'h3004, 32'h3004);
    tbl[28] = mk(1'b0, 5'd13, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, BD_EPC,   BD_CAUSE);
    tbl[29] = mk(1'b0, 5'd12, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, BD_EPC,   32'hFC03);
    tbl[30] = mk(1'b0, 5'd12, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, BD_EPC,   32'hFC01);
    tbl[31] = mk(1'b0, 5'd12, 32'h0, 6'h00, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, BD_EPC,   32'hFC01);
    tbl[32] = mk(1'b0, 5'd12, 32'h0, 6'h01, 1'b0, 5'd0,  32'h3050, 1'b0, 1'b0, 1'b1, BD_EPC,   32'hFC01);
    tbl[33] = mk(1'b0, 5'd12, 32'h0, 6'h3F, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 32'h3050, 32'hFC03);

    reset = 1'b1;
    drive(mk(1'b0, 5'd0, 32'h0, 6'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    repeat (2) begin
      @(posedge clk);
      model_step();
    end
    #1;
    reset = 1'b0;

    for (int i = 0; i < 34; i++) begin
      drive(tbl[i]);
      tag = $sformatf("vec%0d", i);
      run_cycle(tag, tbl[i].e_int, tbl[i].e_epc, tbl[i].e_rd);
    end

    // Reset while in HANDLER with all interrupt lines high.
    reset = 1'b1;
    HWInt = 6'h3F;
    @(posedge clk);
    model_step();
    #1;
    reset = 1'b0;
    CP0Addr = 5'd12;
    run_cycle("rst_hdl sr", 1'b0, 32'h0, 32'h0);
    CP0Addr = 5'd14;
    run_cycle("rst_hdl epc", 1'b0, 32'h0, 32'h0);
    HWInt = 6'h00;
    CP0Addr = 5'd13;
    run_cycle("rst_hdl cause", 1'b0, 32'h0, 32'h0000_FC00);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) == 0);
      HWInt      = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00;
      ExcReq     = ($urandom_range(0, 7) == 0);
      ExcCode_In = 5'($urandom);
      PC_M       = $urandom;
      BD_In      = 1'($urandom);
      CP0We      = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       CP0Addr = 5'd12;
        1:       CP0Addr = 5'd13;
        2:       CP0Addr = 5'd14;
        3:       CP0Addr = 5'd15;
        default: CP0Addr = 5'($urandom);
      endcase
      CP0DataIn  = $urandom;
      EXLClr     = ($urandom_range(0, 5) == 0);
      tag = $sformatf("rnd%0d", n);
      run_cycle(tag, m_int() | m_exc(), m_epc, m_read(CP0Addr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
